// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC3 memory sequencer
package lc3_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_ACCESS,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/lc3_rr_arb2.sv
// rtl/lc3_rr_arb2.sv - two-way round-robin arbiter between fetch and data ports
module lc3_rr_arb2
  import lc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_fetch,
  input  logic       req_data,
  input  logic       update,
  output logic [1:0] grant,
  output logic       winner_id
);

  logic last_q;
  logic last_d;

  // Starting from "fetch last" hands the first conflict after reset to data.
  always_comb begin
    if (req_fetch && req_data) begin
      winner_id = (last_q == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (req_data) begin
      winner_id = REQ_DATA;
    end else begin
      winner_id = REQ_FETCH;
    end
    grant = 2'b00;
    if (req_fetch || req_data) begin
      grant[winner_id] = 1'b1;
    end
    last_d = (update && (req_fetch || req_data)) ? winner_id : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_FETCH;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/lc3_mem_sequencer.sv
// rtl/lc3_mem_sequencer.sv - LC3_MIO bus-cycle sequencer for fetch and load/store ports
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_wdata,
  output logic        data_ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] mio_databus,
  output logic        mio_en,
  output logic        mio_r_w,
  output logic        mio_ld_mar,
  output logic        mio_ld_mdr,
  output logic        mio_gate_mdr,
  input  logic [15:0] mio_mdr,
  input  logic        mio_r
);

  localparam logic [7:0] ACCESS_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        id_q, id_d;
  logic        err_q, err_d;

  logic [1:0]  arb_grant;
  logic        arb_winner;
  logic        arb_update;
  logic        timeout;

  assign arb_update = (state_q == ST_IDLE) && (fetch_req || data_req);
  // cnt_q holds the ACCESS cycles already spent, so the abort lands on cycle TIMEOUT_CYCLES+1.
  assign timeout    = (cnt_q == ACCESS_LIMIT);

  lc3_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (reset),
    .req_fetch (fetch_req),
    .req_data  (data_req),
    .update    (arb_update),
    .grant     (arb_grant),
    .winner_id (arb_winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (fetch_req || data_req) state_d = ST_ADDR;
      ST_ADDR:    state_d = (we_q == RW_WRITE) ? ST_WDATA : ST_ACCESS;
      ST_WDATA:   state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (mio_r) begin
          state_d = (we_q == RW_WRITE) ? ST_DONE : ST_CAPTURE;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_ack    = 1'b0;
    data_ack     = 1'b0;
    err          = 1'b0;
    busy         = (state_q != ST_IDLE);
    mio_databus  = 16'h0000;
    mio_en       = 1'b0;
    mio_r_w      = RW_READ;
    mio_ld_mar   = 1'b0;
    mio_ld_mdr   = 1'b0;
    mio_gate_mdr = 1'b0;
    case (state_q)
      ST_ADDR: begin
        mio_databus = addr_q;
        mio_ld_mar  = 1'b1;
      end
      ST_WDATA: begin
        mio_databus = wdata_q;
        mio_ld_mdr  = 1'b1;
      end
      ST_ACCESS: begin
        mio_en     = 1'b1;
        mio_r_w    = (we_q == RW_WRITE) ? RW_WRITE : RW_READ;
        mio_ld_mdr = (we_q == RW_READ);
      end
      ST_CAPTURE: mio_gate_mdr = 1'b1;
      ST_DONE: begin
        fetch_ack = (id_q == REQ_FETCH);
        data_ack  = (id_q == REQ_DATA);
        err       = err_q;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_update) begin
          id_d    = arb_winner;
          addr_d  = arb_grant[REQ_DATA] ? data_addr : fetch_addr;
          we_d    = arb_grant[REQ_DATA] ? data_we : RW_READ;
          wdata_d = data_wdata;
          err_d   = 1'b0;
        end
      end
      ST_ADDR, ST_WDATA: cnt_d = 8'd0;
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (!mio_r && timeout) err_d = 1'b1;
      end
      ST_CAPTURE: rdata_d = mio_mdr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      cnt_q   <= 8'd0;
      we_q    <= RW_READ;
      id_q    <= REQ_FETCH;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

endmodule
